neo_pal_out: RTL and testbench
==============================

NEO_PAL_OUT -- requirements
Module: neo_pal_out

Interface
REQ-001 SHALL have parameter PIPE_PIX, default 2, fixed: PA-to-RGB latency in pixel enables.
REQ-002 SHALL have port CLK  in  1  system clock, the only clock; every flop is on its rising edge.
REQ-003 SHALL have port nRST  in  1  asynchronous active-low reset.
REQ-004 SHALL have port PIX_CE  in  1  6 MHz pixel enable; single-cycle pulse, period >= 4 CLK.
REQ-005 SHALL have port PA  in  12  palette address from neo_b1; sampled on PIX_CE.
REQ-006 SHALL have port PAL_BANK  in  1  palette bank select; sampled with PA.
REQ-007 SHALL have port SHADOW  in  1  shadow mode, halves intensity; sampled with PA.
REQ-008 SHALL have ports HS_IN, VS_IN, DE_IN  in  1 each  raw syncs and display enable; sampled with PA.
REQ-009 SHALL have ports CPU_REQ  in  1, CPU_WE  in  1, CPU_ADDR  in  13 ({bank,index}), CPU_DIN  in  16, CPU_BE  in  2 ({UDS,LDS} active-high).
REQ-010 SHALL have ports CPU_DOUT  out  16 and CPU_ACK  out  1 (single-cycle completion pulse).
REQ-011 SHALL have ports R, G, B  out  8 each, HS, VS, DE  out  1 each.

Function
REQ-012 SHALL hold an internal palette RAM of 8192 x 16 addressed {bank,index}.
REQ-013 On PIX_CE, SHALL register PA, PAL_BANK, SHADOW, HS_IN, VS_IN and DE_IN into stage 1.
REQ-014 The cycle after PIX_CE is the video slot: SHALL present {bank,PA} to RAM and capture the read word the following cycle.
REQ-015 On the next PIX_CE, SHALL register the converted colour and the stage-1 syncs/DE into the outputs: latency exactly 2 PIX_CE.
REQ-016 Colour word: bit15 = DARK, bits14..12 = R0,G0,B0, bits11..8 = R4..1, 7..4 = G4..1, 3..0 = B4..1.
REQ-017 Each channel SHALL form c6 = {c[4:1], c0, ~DARK}; the 8-bit output = {c6, c6[5:4]}.
REQ-018 When SHADOW is set, SHALL output each 8-bit channel shifted right by 1, zero fill.
REQ-019 When the delayed DE is 0, R/G/B SHALL be 0; HS, VS and DE still pass through.
REQ-020 CPU FSM SHALL have states IDLE, ACCESS and DONE.
REQ-021 IDLE -> ACCESS when CPU_REQ=1 and the current cycle is not the video slot; otherwise it waits in IDLE.
REQ-022 ACCESS SHALL last 1 cycle: write with CPU_BE byte masking, or read address issue.
REQ-023 ACCESS SHALL never coincide with the video slot; the period >= 4 rule guarantees this.
REQ-024 DONE SHALL pulse CPU_ACK for 1 cycle; on a read it SHALL load CPU_DOUT with RAM data, held until the next read.
REQ-025 DONE SHALL then return to IDLE; CPU_REQ still high after DONE starts a new access.
REQ-026 A CPU write and a video read of the same address SHALL be serialised: the video read returns the old word if it comes first, the new word if the write comes first.
REQ-027 CPU_BE=00 on a write SHALL leave RAM unchanged and still acknowledge.
REQ-028 Address arithmetic SHALL be unsigned, with no wrap beyond 13 bits.

Reset
REQ-029 nRST low SHALL asynchronously clear all pipeline registers, the FSM (to IDLE), CPU_ACK, CPU_DOUT, R/G/B, HS, VS and DE to 0.
REQ-030 Reset mid-access SHALL abort the access with no ACK; a write in ACCESS at reset MAY be lost.
REQ-031 RAM contents SHALL NOT be cleared by reset.

Structure
REQ-032 Shared package neo_video_pkg SHALL hold the colour-word bit positions, the FSM state enum and the palette depth constant (8192).
REQ-033 The palette RAM SHALL be a single-port, byte-enabled sub-module neo_pal_ram, 8192x16 with 1-cycle read latency.

Verification
REQ-034 Write 0x7FFF to {0,0x001}, drive PA=0x001 with DE=1 -> after 2 PIX_CE R=G=B=0xFF.
REQ-035 Word 0x8000 with DE=1 -> R=G=B=0x00; word 0x0000 -> R=G=B=0x04 (~DARK bit).
REQ-036 Word 0x7FFF with SHADOW=1 -> R=G=B=0x7F; same pixel with DE=0 -> RGB 0 while HS/VS are delayed by 2 PIX_CE.
REQ-037 CPU_REQ asserted in the video slot -> ACCESS delayed by 1 cycle; ACK 2 cycles after acceptance; the video pixel is uncorrupted.
REQ-038 Write 0x1234 with BE=01 over 0xFFFF, then read -> CPU_DOUT=0xFF34 with a single ACK pulse.
REQ-039 nRST pulsed while in ACCESS -> no ACK, all outputs 0; after release, RAM contents are preserved.

Source files
------------

// File: rtl/neo_video_pkg.sv
`default_nettype none
// ============================================================================
//  Package     : neo_video_pkg
//  Description : Shared palette/video definitions: palette geometry, colour
//                word bit positions, CPU access FSM states and the channel
//                expansion helper.
//  Revision    : 1.0 - initial release
// ============================================================================
package neo_video_pkg;

    // Palette geometry: {bank, index} addressing, 2 banks x 4096 entries
    localparam int c_PAL_DEPTH = 8192;
    localparam int c_PAL_AW    = $clog2(c_PAL_DEPTH);

    // Colour word layout
    localparam int c_DARK_BIT  = 15;
    localparam int c_R0_BIT    = 14;
    localparam int c_G0_BIT    = 13;
    localparam int c_B0_BIT    = 12;
    localparam int c_R_HI_LSB  = 8;
    localparam int c_G_HI_LSB  = 4;
    localparam int c_B_HI_LSB  = 0;

    // CPU palette access sequencer
    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_DONE   = 2'd2
    } cpu_state_t;

    // 5-bit channel plus the inverted DARK bit form a 6-bit level, which is
    // widened to 8 bits by replicating its two MSBs into the bottom.
    function automatic logic [7:0] pal_chan(input logic [3:0] hi,
                                            input logic       lo,
                                            input logic       dark);
        logic [5:0] c6;
        c6 = {hi, lo, ~dark};
        return {c6, c6[5:4]};
    endfunction

endpackage
`default_nettype wire

// File: rtl/neo_pal_ram.sv
`default_nettype none
// ============================================================================
//  Module      : neo_pal_ram
//  Description : Single-port 8192x16 palette RAM with byte write enables and
//                a registered (1-cycle) read port. Contents are never reset.
//  Revision    : 1.0 - initial release
// ============================================================================
module neo_pal_ram
    import neo_video_pkg::*;
(
    input  logic                CLK,
    input  logic                i_en,
    input  logic                i_we,
    input  logic [1:0]          i_be,
    input  logic [c_PAL_AW-1:0] i_addr,
    input  logic [15:0]         i_din,
    output logic [15:0]         o_dout
);

    logic [15:0] r_mem [0:c_PAL_DEPTH-1];

    // Byte-masked write or registered read, one operation per enabled cycle
    always_ff @(posedge CLK) begin
        if (i_en) begin
            if (i_we) begin
                if (i_be[1]) r_mem[i_addr][15:8] <= i_din[15:8];
                if (i_be[0]) r_mem[i_addr][7:0]  <= i_din[7:0];
            end else begin
                o_dout <= r_mem[i_addr];
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/neo_pal_out.sv
`default_nettype none
// ============================================================================
//  Module      : neo_pal_out
//  Description : Palette lookup and RGB output stage. Pixel attributes are
//                sampled on PIX_CE, looked up in the palette RAM during the
//                following cycle (video slot) and presented as 8-bit RGB with
//                delayed syncs on the next PIX_CE. CPU accesses share the
//                single RAM port outside the video slot.
//  Revision    : 1.0 - initial release
// ============================================================================
module neo_pal_out
    import neo_video_pkg::*;
#(
    parameter int PIPE_PIX = 2
)(
    input  logic        CLK,
    input  logic        nRST,
    input  logic        PIX_CE,
    input  logic [11:0] PA,
    input  logic        PAL_BANK,
    input  logic        SHADOW,
    input  logic        HS_IN,
    input  logic        VS_IN,
    input  logic        DE_IN,
    input  logic        CPU_REQ,
    input  logic        CPU_WE,
    input  logic [12:0] CPU_ADDR,
    input  logic [15:0] CPU_DIN,
    input  logic [1:0]  CPU_BE,
    output logic [15:0] CPU_DOUT,
    output logic        CPU_ACK,
    output logic [7:0]  R,
    output logic [7:0]  G,
    output logic [7:0]  B,
    output logic        HS,
    output logic        VS,
    output logic        DE
);

    // Stage 1 pixel attributes
    logic [11:0]         r_s1_pa;
    logic                r_s1_bank, r_s1_shadow, r_s1_hs, r_s1_vs, r_s1_de;
    // Video slot tracking and captured palette word
    logic                r_vslot, r_vcap;
    logic [15:0]         r_vword;
    // CPU sequencer
    cpu_state_t          r_state, w_state_nxt;
    logic                w_accept, w_access;
    logic                r_cpu_we;
    logic [c_PAL_AW-1:0] r_cpu_addr;
    logic [15:0]         r_cpu_din;
    logic [1:0]          r_cpu_be;
    // RAM port
    logic                w_ram_en, w_ram_we;
    logic [c_PAL_AW-1:0] w_ram_addr;
    logic [15:0]         w_ram_dout;
    // Converted colour
    logic [7:0]          w_r, w_g, w_b;

    // Pixel sample, video slot marker and palette word capture
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            r_s1_pa     <= '0;
            r_s1_bank   <= 1'b0;
            r_s1_shadow <= 1'b0;
            r_s1_hs     <= 1'b0;
            r_s1_vs     <= 1'b0;
            r_s1_de     <= 1'b0;
            r_vslot     <= 1'b0;
            r_vcap      <= 1'b0;
            r_vword     <= '0;
        end else begin
            r_vslot <= PIX_CE;
            r_vcap  <= r_vslot;
            if (PIX_CE) begin
                r_s1_pa     <= PA;
                r_s1_bank   <= PAL_BANK;
                r_s1_shadow <= SHADOW;
                r_s1_hs     <= HS_IN;
                r_s1_vs     <= VS_IN;
                r_s1_de     <= DE_IN;
            end
            if (r_vcap) begin
                r_vword <= w_ram_dout;
            end
        end
    end

    // CPU sequencer state register
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // CPU sequencer next state: ACCESS must never land on the video slot, so
    // a request is refused while PIX_CE is high (slot next) or in the slot.
    always_comb begin
        w_state_nxt = r_state;
        w_accept    = 1'b0;
        w_access    = 1'b0;
        CPU_ACK     = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (CPU_REQ && !r_vslot && !PIX_CE) begin
                    w_accept    = 1'b1;
                    w_state_nxt = ST_ACCESS;
                end
            end
            ST_ACCESS: begin
                w_access    = 1'b1;
                w_state_nxt = ST_DONE;
            end
            ST_DONE: begin
                CPU_ACK     = 1'b1;
                w_state_nxt = ST_IDLE;
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // CPU request capture at acceptance and read-data return in DONE
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            r_cpu_we   <= 1'b0;
            r_cpu_addr <= '0;
            r_cpu_din  <= '0;
            r_cpu_be   <= '0;
            CPU_DOUT   <= '0;
        end else begin
            if (w_accept) begin
                r_cpu_we   <= CPU_WE;
                r_cpu_addr <= CPU_ADDR;
                r_cpu_din  <= CPU_DIN;
                r_cpu_be   <= CPU_BE;
            end
            if ((r_state == ST_DONE) && !r_cpu_we) begin
                CPU_DOUT <= w_ram_dout;
            end
        end
    end

    // RAM port arbitration: CPU in ACCESS, otherwise the video address
    always_comb begin
        w_ram_addr = w_access ? r_cpu_addr : {r_s1_bank, r_s1_pa};
        w_ram_en   = w_access | r_vslot;
        w_ram_we   = w_access & r_cpu_we;
    end

    neo_pal_ram u_ram (
        .CLK    (CLK),
        .i_en   (w_ram_en),
        .i_we   (w_ram_we),
        .i_be   (r_cpu_be),
        .i_addr (w_ram_addr),
        .i_din  (r_cpu_din),
        .o_dout (w_ram_dout)
    );

    // Colour expansion, shadow halving and blanking outside display enable
    always_comb begin
        w_r = pal_chan(r_vword[c_R_HI_LSB +: 4], r_vword[c_R0_BIT], r_vword[c_DARK_BIT]);
        w_g = pal_chan(r_vword[c_G_HI_LSB +: 4], r_vword[c_G0_BIT], r_vword[c_DARK_BIT]);
        w_b = pal_chan(r_vword[c_B_HI_LSB +: 4], r_vword[c_B0_BIT], r_vword[c_DARK_BIT]);
        if (r_s1_shadow) begin
            w_r = w_r >> 1;
            w_g = w_g >> 1;
            w_b = w_b >> 1;
        end
        if (!r_s1_de) begin
            w_r = '0;
            w_g = '0;
            w_b = '0;
        end
    end

    generate
        if (PIPE_PIX == 2) begin : g_out_pipe2
            // Output stage: second pixel enable of the two-deep pipeline
            always_ff @(posedge CLK or negedge nRST) begin
                if (!nRST) begin
                    R  <= '0;
                    G  <= '0;
                    B  <= '0;
                    HS <= 1'b0;
                    VS <= 1'b0;
                    DE <= 1'b0;
                end else if (PIX_CE) begin
                    R  <= w_r;
                    G  <= w_g;
                    B  <= w_b;
                    HS <= r_s1_hs;
                    VS <= r_s1_vs;
                    DE <= r_s1_de;
                end
            end
        end else begin : g_out_unsupported
            assign {R, G, B, HS, VS, DE} = '0;
        end
    endgenerate

endmodule
`default_nettype wire

// File: tb/tb_neo_pal_out.sv
`default_nettype none
// ============================================================================
//  Module      : tb_neo_pal_out
//  Description : Self-checking bench for neo_pal_out with a behavioural
//                palette model and colour reference.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_neo_pal_out;

    logic        CLK;
    logic        nRST, PIX_CE, PAL_BANK, SHADOW, HS_IN, VS_IN, DE_IN;
    logic [11:0] PA;
    logic        CPU_REQ, CPU_WE;
    logic [12:0] CPU_ADDR;
    logic [15:0] CPU_DIN, CPU_DOUT;
    logic [1:0]  CPU_BE;
    logic        CPU_ACK;
    logic [7:0]  R, G, B;
    logic        HS, VS, DE;

    int          total = 0;
    int          bad   = 0;
    logic [15:0] mdl [0:8191];
    bit          prev_valid = 0;
    logic [26:0] prev_exp;
    string       prev_tag;

    neo_pal_out #(.PIPE_PIX(2)) dut (
        .CLK(CLK), .nRST(nRST), .PIX_CE(PIX_CE), .PA(PA), .PAL_BANK(PAL_BANK),
        .SHADOW(SHADOW), .HS_IN(HS_IN), .VS_IN(VS_IN), .DE_IN(DE_IN),
        .CPU_REQ(CPU_REQ), .CPU_WE(CPU_WE), .CPU_ADDR(CPU_ADDR), .CPU_DIN(CPU_DIN),
        .CPU_BE(CPU_BE), .CPU_DOUT(CPU_DOUT), .CPU_ACK(CPU_ACK),
        .R(R), .G(G), .B(B), .HS(HS), .VS(VS), .DE(DE)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // Reference colour: {R,G,B,HS,VS,DE} from the palette word and attributes
    function automatic logic [26:0] exp_pix(input logic [15:0] w, input bit sh,
                                            input bit hs, input bit vs, input bit de);
        int five [3];
        int six, lvl;
        logic [7:0] ch [3];
        five[0] = int'(w[11:8]) * 2 + int'(w[14]);
        five[1] = int'(w[7:4])  * 2 + int'(w[13]);
        five[2] = int'(w[3:0])  * 2 + int'(w[12]);
        for (int i = 0; i < 3; i++) begin
            six = five[i] * 2 + (w[15] ? 0 : 1);
            lvl = six * 4 + six / 16;
            if (sh) lvl = lvl / 2;
            if (!de) lvl = 0;
            ch[i] = lvl[7:0];
        end
        return {ch[0], ch[1], ch[2], hs, vs, de};
    endfunction

    // One pixel period of 4 clocks; checks the output of the previous pixel
    task automatic pix(input logic [11:0] pa, input bit bank, input bit sh,
                       input bit hs, input bit vs, input bit de, input string tag);
        logic [26:0] cur, got;
        @(negedge CLK);
        PA = pa; PAL_BANK = bank; SHADOW = sh; HS_IN = hs; VS_IN = vs; DE_IN = de;
        PIX_CE = 1'b1;
        cur = exp_pix(mdl[{bank, pa}], sh, hs, vs, de);
        @(negedge CLK);
        PIX_CE = 1'b0;
        got = {R, G, B, HS, VS, DE};
        if (prev_valid) begin
            total++;
            if (got !== prev_exp) begin
                bad++;
                $display("FAIL %s: rgbsync got %h want %h", prev_tag, got, prev_exp);
            end
        end
        prev_exp = cur; prev_valid = 1; prev_tag = tag;
        repeat (2) @(negedge CLK);
    endtask

    // One CPU access with bounded wait for ACK and single-pulse check
    task automatic cpu_op(input bit we, input logic [12:0] addr, input logic [15:0] din,
                          input logic [1:0] be, output logic [15:0] dout, input string tag);
        int n;
        n = 0;
        @(negedge CLK);
        CPU_REQ = 1'b1; CPU_WE = we; CPU_ADDR = addr; CPU_DIN = din; CPU_BE = be;
        while (!CPU_ACK && n < 20) begin
            @(negedge CLK);
            n++;
        end
        CPU_REQ = 1'b0;
        total++;
        if (CPU_ACK !== 1'b1) begin
            bad++;
            $display("FAIL %s_ack: ACK=%b after %0d cycles, want 1", tag, CPU_ACK, n);
        end
        @(negedge CLK);
        total++;
        if (CPU_ACK !== 1'b0) begin
            bad++;
            $display("FAIL %s_ack_pulse: ACK=%b want 0", tag, CPU_ACK);
        end
        dout = CPU_DOUT;
        if (we) begin
            if (be[1]) mdl[addr][15:8] = din[15:8];
            if (be[0]) mdl[addr][7:0]  = din[7:0];
        end
    endtask

    task automatic test_reset();
        PIX_CE = 0; PA = '0; PAL_BANK = 0; SHADOW = 0; HS_IN = 0; VS_IN = 0; DE_IN = 0;
        CPU_REQ = 0; CPU_WE = 0; CPU_ADDR = '0; CPU_DIN = '0; CPU_BE = '0;
        nRST = 1'b0;
        repeat (3) @(negedge CLK);
        total++;
        if ({CPU_ACK, CPU_DOUT, R, G, B, HS, VS, DE} !== 43'd0) begin
            bad++;
            $display("FAIL reset_outputs: got %h want 0", {CPU_ACK, CPU_DOUT, R, G, B, HS, VS, DE});
        end
        nRST = 1'b1;
        prev_exp = '0; prev_valid = 1; prev_tag = "post_reset";
    endtask

    task automatic test_colour();
        logic [15:0] d;
        cpu_op(1, 13'h0001, 16'h7FFF, 2'b11, d, "wr_white");
        cpu_op(1, 13'h0002, 16'h8000, 2'b11, d, "wr_dark");
        cpu_op(1, 13'h0003, 16'h0000, 2'b11, d, "wr_zero");
        pix(12'h001, 0, 0, 1, 0, 1, "c_white");
        pix(12'h002, 0, 0, 0, 0, 1, "c_dark");
        total++;
        if ({R, G, B} !== 24'hFFFFFF) begin bad++; $display("FAIL white_const: got %h want ffffff", {R, G, B}); end
        pix(12'h003, 0, 0, 0, 1, 1, "c_zero");
        total++;
        if ({R, G, B} !== 24'h000000) begin bad++; $display("FAIL dark_const: got %h want 000000", {R, G, B}); end
        pix(12'h000, 0, 0, 0, 0, 0, "c_tail");
        total++;
        if ({R, G, B} !== 24'h040404) begin bad++; $display("FAIL zero_const: got %h want 040404", {R, G, B}); end
    endtask

    task automatic test_shadow_de();
        pix(12'h001, 0, 1, 1, 0, 1, "s_shadow");
        pix(12'h001, 0, 0, 0, 1, 0, "s_blank");
        total++;
        if ({R, G, B, HS, VS, DE} !== {24'h7F7F7F, 3'b101}) begin
            bad++; $display("FAIL shadow_const: got %h want %h", {R, G, B, HS, VS, DE}, {24'h7F7F7F, 3'b101});
        end
        pix(12'h000, 0, 0, 0, 0, 0, "s_tail");
        total++;
        if ({R, G, B, HS, VS, DE} !== {24'h0, 3'b010}) begin
            bad++; $display("FAIL blank_const: got %h want %h", {R, G, B, HS, VS, DE}, {24'h0, 3'b010});
        end
    endtask

    task automatic test_byte_enable();
        logic [15:0] d;
        cpu_op(1, 13'h1ABC, 16'hFFFF, 2'b11, d, "be_init");
        cpu_op(1, 13'h1ABC, 16'h1234, 2'b01, d, "be_lo");
        cpu_op(0, 13'h1ABC, 16'h0000, 2'b00, d, "be_rd1");
        total++;
        if (d !== 16'hFF34) begin bad++; $display("FAIL be_low_byte: got %h want ff34", d); end
        cpu_op(1, 13'h1ABC, 16'hAAAA, 2'b00, d, "be_none");
        cpu_op(0, 13'h1ABC, 16'h0000, 2'b00, d, "be_rd2");
        total++;
        if (d !== 16'hFF34) begin bad++; $display("FAIL be_zero_mask: got %h want ff34", d); end
        cpu_op(1, 13'h0ABC, 16'h5678, 2'b10, d, "be_hi_other");
        cpu_op(0, 13'h1ABC, 16'h0000, 2'b00, d, "be_rd3");
        total++;
        if (d !== mdl[13'h1ABC]) begin bad++; $display("FAIL be_bank_isolation: got %h want %h", d, mdl[13'h1ABC]); end
    endtask

    task automatic test_slot_collision();
        logic [15:0] d;
        logic [26:0] cur, got;
        int n;
        cpu_op(1, 13'h0055, 16'h1111, 2'b11, d, "col_init");
        pix(12'h000, 0, 0, 0, 0, 0, "col_flush");
        @(negedge CLK);
        PA = 12'h055; PAL_BANK = 0; SHADOW = 0; HS_IN = 1; VS_IN = 1; DE_IN = 1; PIX_CE = 1'b1;
        cur = exp_pix(mdl[13'h0055], 0, 1, 1, 1);
        @(negedge CLK);
        PIX_CE = 1'b0;
        got = {R, G, B, HS, VS, DE};
        total++;
        if (got !== prev_exp) begin bad++; $display("FAIL %s: rgbsync got %h want %h", prev_tag, got, prev_exp); end
        // Now inside the video slot: request a write to the address being read
        CPU_REQ = 1'b1; CPU_WE = 1'b1; CPU_ADDR = 13'h0055; CPU_DIN = 16'h2222; CPU_BE = 2'b11;
        n = 0;
        while (!CPU_ACK && n < 20) begin
            @(negedge CLK);
            n++;
        end
        CPU_REQ = 1'b0;
        total++;
        if (n != 3) begin bad++; $display("FAIL col_ack_latency: got %0d cycles want 3", n); end
        mdl[13'h0055] = 16'h2222;
        prev_exp = cur; prev_valid = 1; prev_tag = "col_old_word";
        pix(12'h055, 0, 0, 0, 0, 1, "col_new_word");
        pix(12'h000, 0, 0, 0, 0, 0, "col_tail");
    endtask

    task automatic test_back_to_back();
        int acks;
        acks = 0;
        @(negedge CLK);
        CPU_REQ = 1'b1; CPU_WE = 1'b0; CPU_ADDR = 13'h1ABC;
        repeat (12) begin
            @(negedge CLK);
            if (CPU_ACK) acks++;
        end
        CPU_REQ = 1'b0;
        total++;
        if (acks != 4) begin bad++; $display("FAIL b2b_ack_count: got %0d want 4", acks); end
        repeat (2) @(negedge CLK);
        total++;
        if (CPU_DOUT !== mdl[13'h1ABC]) begin bad++; $display("FAIL b2b_dout: got %h want %h", CPU_DOUT, mdl[13'h1ABC]); end
    endtask

    task automatic test_random();
        logic [12:0] addrs [16];
        logic [15:0] d;
        int k;
        for (int i = 0; i < 16; i++) begin
            addrs[i] = 13'($urandom_range(16, 8191));
            cpu_op(1, addrs[i], 16'($urandom), 2'b11, d, "rnd_init");
        end
        for (int i = 0; i < 40; i++) begin
            k = $urandom_range(0, 15);
            case ($urandom_range(0, 2))
                0: cpu_op(1, addrs[k], 16'($urandom), 2'($urandom), d, "rnd_wr");
                1: begin
                    cpu_op(0, addrs[k], 16'h0000, 2'b00, d, "rnd_rd");
                    total++;
                    if (d !== mdl[addrs[k]]) begin
                        bad++; $display("FAIL rnd_read: addr %h got %h want %h", addrs[k], d, mdl[addrs[k]]);
                    end
                end
                default: ;
            endcase
            k = $urandom_range(0, 15);
            pix(addrs[k][11:0], addrs[k][12], 1'($urandom), 1'($urandom), 1'($urandom),
                1'($urandom), "rnd_pix");
        end
        pix(12'h000, 0, 0, 0, 0, 0, "rnd_tail");
    endtask

    task automatic test_reset_mid_access();
        logic [15:0] d;
        int acks;
        cpu_op(1, 13'h0001, 16'h7FFF, 2'b11, d, "rm_init");
        cpu_op(0, 13'h1ABC, 16'h0000, 2'b00, d, "rm_pre_rd");
        pix(12'h001, 0, 0, 1, 1, 1, "rm_a");
        pix(12'h001, 0, 0, 1, 1, 1, "rm_b");
        @(negedge CLK);
        CPU_REQ = 1'b1; CPU_WE = 1'b1; CPU_ADDR = 13'h0001; CPU_DIN = 16'h0000; CPU_BE = 2'b11;
        @(negedge CLK);
        nRST = 1'b0;
        #1;
        total++;
        if ({CPU_ACK, CPU_DOUT, R, G, B, HS, VS, DE} !== 43'd0) begin
            bad++; $display("FAIL rm_outputs: got %h want 0", {CPU_ACK, CPU_DOUT, R, G, B, HS, VS, DE});
        end
        CPU_REQ = 1'b0;
        acks = 0;
        repeat (3) begin
            @(negedge CLK);
            if (CPU_ACK) acks++;
        end
        total++;
        if (acks != 0) begin bad++; $display("FAIL rm_no_ack: got %0d acks want 0", acks); end
        nRST = 1'b1;
        prev_exp = '0; prev_valid = 1; prev_tag = "rm_post_reset";
        cpu_op(0, 13'h0002, 16'h0000, 2'b00, d, "rm_rd_a");
        total++;
        if (d !== mdl[13'h0002]) begin bad++; $display("FAIL rm_ram_kept_a: got %h want %h", d, mdl[13'h0002]); end
        cpu_op(0, 13'h1ABC, 16'h0000, 2'b00, d, "rm_rd_b");
        total++;
        if (d !== mdl[13'h1ABC]) begin bad++; $display("FAIL rm_ram_kept_b: got %h want %h", d, mdl[13'h1ABC]); end
        pix(12'h002, 0, 0, 0, 0, 0, "rm_pix");
    endtask

    initial begin
        test_reset();
        test_colour();
        test_shadow_de();
        test_byte_enable();
        test_slot_collision();
        test_back_to_back();
        test_random();
        test_reset_mid_access();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
